// File: rtl/cmd_burst_int_pkg.sv
// cmd_pkg: shared FSM states, error flag indices and header field positions for cmd_burst_int.
package cmd_pkg;
    typedef enum logic [2:0] {IDLE, LEN, WDATA, WREQ, RREQ, RSEND} cmd_state_e;
    localparam int ERR_LEN = 0;
    localparam int ERR_OVR = 1;
    localparam int ERR_TMO = 2;
    localparam int HDR_WR_BIT = 7;
    localparam int HDR_ADDR_MSB = 6;
    localparam int HDR_ADDR_LSB = 0;
endpackage

// File: rtl/cmd_timeout_cnt.sv
// cmd_timeout_cnt: counts idle cycles while enabled and pulses expire_o when LIMIT cycles have passed.
module cmd_timeout_cnt #(
    parameter int LIMIT = 100000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);
    localparam int CW = $clog2(LIMIT + 1);
    logic [CW-1:0] cnt;
    assign expire_o = en_i && !clr_i && cnt == CW'(LIMIT - 1);
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt <= '0;
        else cnt <= (!en_i || clr_i || expire_o) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/cmd_burst_int.sv
// cmd_burst_int: decodes UART header/length/data frames into burst register accesses.
// Optional inter-byte timeout is enabled by defining CMD_INT_TIMEOUT_EN.
module cmd_burst_int
    import cmd_pkg::*;
#(
    parameter int DATA_BYTES = 1,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    rx_valid_i,
    input  logic [7:0]              rx_data_i,
    output logic                    tx_valid_o,
    output logic [7:0]              tx_data_o,
    input  logic                    tx_ready_i,
    output logic                    req_o,
    output logic                    wr_o,
    output logic [6:0]              addr_o,
    output logic [8*DATA_BYTES-1:0] wdata_o,
    input  logic [8*DATA_BYTES-1:0] rdata_i,
    input  logic                    ack_i,
    output logic [2:0]              err_o,
    input  logic                    err_clr_i
);
    localparam int DW = 8 * DATA_BYTES;
    localparam logic [1:0] BLAST = 2'(DATA_BYTES - 1);
    cmd_state_e state, nxt;
    logic          wr_q, last_b, clamp, tmo, adv;
    logic [7:0]    rem;
    logic [1:0]    bcnt;
    logic [DW-1:0] shift, wdata_n, shift_n;
    logic [2:0]    err_set;

    assign last_b = bcnt == BLAST;
    assign clamp = {1'b0, rx_data_i} >= 9'(MAX_BURST);
    assign adv = rem != 8'd0 && ((state == WREQ && ack_i) || (state == RSEND && tx_ready_i && last_b));

    // Little-endian assembly: bytes enter at the top and end up at [7:0] first.
    if (DATA_BYTES == 1) begin : g_one
        assign wdata_n = rx_data_i;
        assign shift_n = shift;
    end else begin : g_multi
        assign wdata_n = {rx_data_i, wdata_o[DW-1:8]};
        assign shift_n = {8'h00, shift[DW-1:8]};
    end

`ifdef CMD_INT_TIMEOUT_EN
    cmd_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_tmo (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .en_i     (state == LEN || state == WDATA),
        .clr_i    (rx_valid_i),
        .expire_o (tmo)
    );
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = rx_valid_i ? LEN : IDLE;
            LEN:     nxt = tmo ? IDLE : !rx_valid_i ? LEN : wr_q ? WDATA : RREQ;
            WDATA:   nxt = tmo ? IDLE : (rx_valid_i && last_b) ? WREQ : WDATA;
            WREQ:    nxt = !ack_i ? WREQ : rem == 8'd0 ? IDLE : WDATA;
            RREQ:    nxt = ack_i ? RSEND : RREQ;
            RSEND:   nxt = !(tx_ready_i && last_b) ? RSEND : rem == 8'd0 ? IDLE : RREQ;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        req_o = state == WREQ || state == RREQ;
        wr_o = state == WREQ;
        tx_valid_o = state == RSEND;
        tx_data_o = shift[7:0];
    end

    always_comb begin
        err_set = '0;
        err_set[ERR_LEN] = state == LEN && rx_valid_i && clamp;
        err_set[ERR_OVR] = rx_valid_i && (state == WREQ || state == RREQ || state == RSEND);
        err_set[ERR_TMO] = tmo;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q <= 1'b0;
            addr_o <= '0;
            rem <= '0;
            bcnt <= '0;
            wdata_o <= '0;
            shift <= '0;
            err_o <= '0;
        end else begin
            err_o <= (err_clr_i ? 3'b000 : err_o) | err_set;
            if (state == IDLE && rx_valid_i) begin
                wr_q <= rx_data_i[HDR_WR_BIT];
                addr_o <= rx_data_i[HDR_ADDR_MSB:HDR_ADDR_LSB];
            end
            if (state == LEN && rx_valid_i) begin
                rem <= clamp ? 8'(MAX_BURST - 1) : rx_data_i;
                bcnt <= '0;
            end
            if (state == WDATA && rx_valid_i) begin
                wdata_o <= wdata_n;
                bcnt <= last_b ? 2'd0 : bcnt + 1'b1;
            end
            if (state == RREQ && ack_i) begin
                shift <= rdata_i;
                bcnt <= '0;
            end
            if (state == RSEND && tx_ready_i) begin
                shift <= shift_n;
                bcnt <= last_b ? 2'd0 : bcnt + 1'b1;
            end
            if (adv) begin
                rem <= rem - 1'b1;
                addr_o <= addr_o + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cmd_burst_int.sv
// tb_cmd_burst_int: directed table-driven bench for cmd_burst_int with DATA_BYTES=2, MAX_BURST=16.
module tb_cmd_burst_int;
    logic        clk_i = 1'b0, rst_n_i = 1'b0, rx_valid_i = 1'b0, tx_ready_i = 1'b0;
    logic        ack_i = 1'b0, err_clr_i = 1'b0;
    logic [7:0]  rx_data_i = '0;
    logic [15:0] rdata_i = '0;
    logic        tx_valid_o, req_o, wr_o;
    logic [7:0]  tx_data_o;
    logic [6:0]  addr_o;
    logic [15:0] wdata_o;
    logic [2:0]  err_o;
    int checks = 0, errors = 0;

    cmd_burst_int #(.DATA_BYTES(2), .MAX_BURST(16), .TIMEOUT_CYC(50)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
        .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
        .req_o(req_o), .wr_o(wr_o), .addr_o(addr_o), .wdata_o(wdata_o), .rdata_i(rdata_i),
        .ack_i(ack_i), .err_o(err_o), .err_clr_i(err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0]  hdr;
        logic [15:0] wd;
        logic [15:0] rd;
        logic        exp_wr;
        logic [6:0]  exp_addr;
        logic [15:0] exp_wdata;
        logic [7:0]  tx0;
        logic [7:0]  tx1;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic rx(input logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_data_i = b;
        tick();
        rx_valid_i = 1'b0;
    endtask

    task automatic ack_word(input logic [15:0] rd);
        ack_i = 1'b1;
        rdata_i = rd;
        tick();
        ack_i = 1'b0;
    endtask

    task automatic txacc;
        tx_ready_i = 1'b1;
        tick();
        tx_ready_i = 1'b0;
    endtask

    task automatic clr_err;
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
    endtask

    initial begin
        int n;
        vecs[0] = '{8'h85, 16'h1234, 16'h0000, 1'b1, 7'h05, 16'h1234, 8'h00, 8'h00};
        vecs[1] = '{8'hFF, 16'hBEEF, 16'h0000, 1'b1, 7'h7F, 16'hBEEF, 8'h00, 8'h00};
        vecs[2] = '{8'h80, 16'h0001, 16'h0000, 1'b1, 7'h00, 16'h0001, 8'h00, 8'h00};
        vecs[3] = '{8'h12, 16'h0000, 16'hA55A, 1'b0, 7'h12, 16'h0000, 8'h5A, 8'hA5};
        vecs[4] = '{8'h7F, 16'h0000, 16'h00FF, 1'b0, 7'h7F, 16'h0000, 8'hFF, 8'h00};

        tick();
        tick();
        chk("rst_outputs", {tx_valid_o, tx_data_o, req_o, wr_o, addr_o, err_o}, '0);
        chk("rst_wdata", wdata_o, 16'h0000);
        rst_n_i = 1'b1;
        tick();
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("stray_ack", {req_o, tx_valid_o}, 2'b00);

        for (int i = 0; i < 5; i++) begin
            rx(vecs[i].hdr);
            rx(8'h00);
            if (vecs[i].hdr[7]) begin
                rx(vecs[i].wd[7:0]);
                rx(vecs[i].wd[15:8]);
            end
            chk($sformatf("v%0d_req", i), req_o, 1'b1);
            chk($sformatf("v%0d_wr", i), wr_o, vecs[i].exp_wr);
            chk($sformatf("v%0d_addr", i), addr_o, vecs[i].exp_addr);
            if (vecs[i].exp_wr) chk($sformatf("v%0d_wdata", i), wdata_o, vecs[i].exp_wdata);
            ack_word(vecs[i].rd);
            chk($sformatf("v%0d_req_drop", i), req_o, 1'b0);
            if (!vecs[i].exp_wr) begin
                chk($sformatf("v%0d_tx0", i), {tx_valid_o, tx_data_o}, {1'b1, vecs[i].tx0});
                txacc();
                chk($sformatf("v%0d_tx1", i), {tx_valid_o, tx_data_o}, {1'b1, vecs[i].tx1});
                txacc();
            end
            chk($sformatf("v%0d_idle", i), {req_o, tx_valid_o}, 2'b00);
        end

        // two-word read burst wrapping the address 0x7F -> 0x00
        rx(8'h7F);
        rx(8'h01);
        chk("wrap_addr0", {req_o, addr_o}, {1'b1, 7'h7F});
        ack_word(16'h11AA);
        chk("wrap_tx0", tx_data_o, 8'hAA);
        txacc();
        chk("wrap_tx1", tx_data_o, 8'h11);
        txacc();
        chk("wrap_addr1", {req_o, wr_o, addr_o}, {1'b1, 1'b0, 7'h00});
        ack_word(16'h22BB);
        chk("wrap_tx2", {tx_valid_o, tx_data_o}, {1'b1, 8'hBB});
        txacc();
        chk("wrap_tx3", tx_data_o, 8'h22);
        txacc();
        chk("wrap_idle", {req_o, tx_valid_o}, 2'b00);

        // length 0x20 clamps to 16 words
        rx(8'h01);
        rx(8'h20);
        n = 0;
        tx_ready_i = 1'b1;
        for (int c = 0; c < 200; c++) begin
            ack_i = req_o;
            if (req_o) n++;
            tick();
        end
        ack_i = 1'b0;
        tx_ready_i = 1'b0;
        chk("clamp_count", n, 16);
        chk("clamp_err", err_o, 3'b001);
        chk("clamp_last_addr", addr_o, 7'h10);
        clr_err();
        chk("clamp_clr", err_o, 3'b000);

        // overrun while a tx byte is pending
        rx(8'h03);
        rx(8'h00);
        ack_word(16'hC3D4);
        rx(8'h99);
        chk("ovr_err", err_o, 3'b010);
        chk("ovr_tx_hold", {tx_valid_o, tx_data_o}, {1'b1, 8'hD4});
        clr_err();
        chk("ovr_clr", err_o, 3'b000);
        err_clr_i = 1'b1;
        rx(8'h55);
        err_clr_i = 1'b0;
        chk("ovr_set_wins", err_o, 3'b010);
        clr_err();
        chk("ovr_tx_b0", tx_data_o, 8'hD4);
        txacc();
        chk("ovr_tx_b1", tx_data_o, 8'hC3);
        txacc();
        chk("ovr_idle", {req_o, tx_valid_o, err_o}, 5'b00000);

        // asynchronous reset while a write waits for ack
        rx(8'h8A);
        rx(8'h00);
        rx(8'h11);
        rx(8'h22);
        chk("rstw_req", req_o, 1'b1);
        rst_n_i = 1'b0;
        #1;
        chk("rstw_async", {req_o, wr_o, addr_o}, '0);
        chk("rstw_wdata", wdata_o, 16'h0000);
        #2 rst_n_i = 1'b1;
        tick();
        rx(8'h83);
        rx(8'h00);
        rx(8'h78);
        rx(8'h56);
        chk("rstw_new", {req_o, wr_o, addr_o}, {1'b1, 1'b1, 7'h03});
        chk("rstw_new_data", wdata_o, 16'h5678);
        ack_word(16'h0000);
        chk("rstw_new_done", req_o, 1'b0);

        // header followed by silence
        rx(8'h85);
        n = 0;
        for (int c = 0; c < 49; c++) begin
            if (req_o) n++;
            tick();
        end
`ifdef CMD_INT_TIMEOUT_EN
        chk("tmo_before", err_o, 3'b000);
        tick();
        chk("tmo_err", err_o, 3'b100);
        chk("tmo_noreq", n + int'(req_o), 0);
        rx(8'h01);
        rx(8'h00);
        chk("tmo_recover", {req_o, wr_o, addr_o}, {1'b1, 1'b0, 7'h01});
        ack_word(16'h0000);
        txacc();
        txacc();
`else
        tick();
        chk("notmo_err", err_o, 3'b000);
        chk("notmo_noreq", n + int'(req_o), 0);
        rx(8'h00);
        rx(8'hCD);
        rx(8'hAB);
        chk("notmo_req", {req_o, wr_o, addr_o}, {1'b1, 1'b1, 7'h05});
        chk("notmo_data", wdata_o, 16'hABCD);
        ack_word(16'h0000);
`endif
        chk("final_idle", {req_o, tx_valid_o}, 2'b00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cmd_burst_int.md
# cmd_burst_int

Parametrised UART-to-register command interpreter. Sits between the UART byte interface and the register bus (reg_top side), decoding header/length/data byte frames into single-word or auto-incrementing burst register writes and reads. Supports multi-byte data words and streams read data back with a ready/valid handshake. Reports errors through sticky flags.

## Interface
Parameters:
- DATA_BYTES, 1: register word width in bytes, legal 1..4; word width DW = 8*DATA_BYTES
- MAX_BURST, 16: maximum words per command, power of two, legal 1..256
- TIMEOUT_CYC, 100000: inter-byte timeout in clk_i cycles; used only with CMD_INT_TIMEOUT_EN

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- rx_valid_i  in  1  one-cycle strobe, UART byte received
- rx_data_i  in  8  received byte
- tx_valid_o  out  1  byte available for UART transmit
- tx_data_o  out  8  byte to transmit
- tx_ready_i  in  1  UART accepts tx_data_o this cycle
- req_o  out  1  bus request
- wr_o  out  1  1 = write, 0 = read
- addr_o  out  7  register address
- wdata_o  out  DW  write data
- rdata_i  in  DW  read data, sampled on ack_i
- ack_i  in  1  bus completion, meaningful only while req_o = 1
- err_o  out  3  sticky flags: [0] length clamped, [1] rx overrun, [2] rx timeout
- err_clr_i  in  1  clears err_o

## Operation
- Frame: header byte {wr, addr[6:0]}, length byte L (word count L+1), then for writes (L+1)*DATA_BYTES data bytes, little-endian (first byte goes to wdata_o[7:0]).
- States: IDLE, LEN, WDATA, WREQ, RREQ, RSEND.
- IDLE: on rx_valid_i, latch wr and addr, go to LEN.
- LEN: on rx_valid_i, remaining = L. If L >= MAX_BURST, remaining = MAX_BURST-1 and set err_o[0]. Go to WDATA if wr, else RREQ.
- WDATA: shift each byte into the data register. After the DATA_BYTES-th byte, go to WREQ.
- WREQ: req_o=1, wr_o=1. On ack_i: if remaining == 0, go to IDLE. Otherwise decrement remaining, addr+1 (modulo 128, wraps 127->0), go to WDATA.
- RREQ: req_o=1, wr_o=0. On ack_i: load rdata_i into the tx shift register, go to RSEND.
- RSEND: tx_valid_o=1, tx_data_o = shift[7:0]. On tx_ready_i, shift right 8. After DATA_BYTES accepted bytes: if remaining == 0, go to IDLE; otherwise decrement remaining, addr+1, go to RREQ.
- rx_valid_i in WREQ, RREQ or RSEND: byte dropped, err_o[1] set, state unaffected.
- err_o bits are sticky. err_clr_i clears them. A flag setting in the same cycle as err_clr_i wins (the bit reads 1).
- ack_i while req_o = 0: ignored.
- Reset mid-frame: immediate return to IDLE. The partial frame is discarded and no bus access occurs.

## Timing
- Reset values: tx_valid_o 0, tx_data_o 0, req_o 0, wr_o 0, addr_o 0, wdata_o 0, err_o 0, state IDLE, counters 0.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- Last write data byte at cycle N -> req_o=1 at N+1. Length byte of a read at N -> req_o=1 at N+1.
- ack_i in the first req_o cycle is legal: req_o is low in the next cycle.
- ack_i at cycle M (read) -> tx_valid_o=1 with byte 0 at M+1.
- In a burst, the next word's req_o rises 1 cycle after the last tx byte is accepted (read) or after the next word's last byte is received (write).
- tx_valid_o stays high and tx_data_o stays stable until tx_ready_i.

## Configuration
- CMD_INT_TIMEOUT_EN defined: in LEN and WDATA, a counter tracks cycles since the last rx_valid_i. On reaching TIMEOUT_CYC, go to IDLE, set err_o[2], and issue no bus access. The counter resets on every rx_valid_i and on state entry.
- CMD_INT_TIMEOUT_EN not defined: no counter, err_o[2] is tied 0, and TIMEOUT_CYC is unused.

## Structure
- Package cmd_pkg: cmd_state_e enum, err bit index constants (ERR_LEN, ERR_OVR, ERR_TMO), header field positions (HDR_WR_BIT=7, address field [6:0]).
- Sub-module cmd_timeout_cnt (counter plus expire pulse), instantiated only under CMD_INT_TIMEOUT_EN.

## Test plan
- DATA_BYTES=2, write frame 0x85, 0x00, 0x34, 0x12 -> one write req with addr_o=0x05, wdata_o=0x1234, then IDLE.
- Read frame 0x7F, 0x01 with rdata 0xAA then 0xBB (DATA_BYTES=1) -> reads at addresses 0x7F and 0x00, tx bytes 0xAA, 0xBB.
- MAX_BURST=16, length byte 0x20 -> err_o[0]=1, exactly 16 bus accesses.
- Byte received during RSEND with tx_ready_i held low -> err_o[1]=1, tx_data_o unchanged; err_clr_i -> err_o=0.
- With CMD_INT_TIMEOUT_EN and TIMEOUT_CYC=50: header only, then idle for 50 cycles -> IDLE, err_o[2]=1, no req_o.
- rst_n_i asserted in WREQ before ack_i -> req_o=0 immediately; a new frame afterwards is decoded correctly.
